bus_timer: RTL and testbench

//  Memory-mapped 8-bit interval timer on the MPU data bus (downstream of mpu, beside memory).

---
 rtl/bus_timer.sv | 126 ++++++++++++
 tb/tb_bus_timer.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/bus_timer.sv
// rtl/bus_timer.sv - 8-bit memory-mapped interval timer with prescaler and active-low IRQ
// Four byte registers (COUNT, CTRL, STATUS, RELOAD); underflow sets FLAG, optionally raising IRQ_N.
module bus_timer #(
    parameter logic [7:0] RESET_RELOAD = 8'hFF
) (
    input  logic       CLK,
    input  logic       RES_N,
    input  logic       CS,
    input  logic [1:0] A,
    input  logic       R_W,
    input  logic [7:0] DB_IN,
    output logic [7:0] DB_OUT,
    output logic       IRQ_N
);

    localparam logic [1:0] ADDR_COUNT  = 2'd0;
    localparam logic [1:0] ADDR_CTRL   = 2'd1;
    localparam logic [1:0] ADDR_STATUS = 2'd2;
    localparam logic [1:0] ADDR_RELOAD = 2'd3;

    logic [7:0] count_q,  count_d;
    logic [7:0] reload_q, reload_d;
    logic [9:0] presc_q,  presc_d;
    logic [1:0] div_q,    div_d;
    logic       run_q,    run_d;
    logic       auto_q,   auto_d;
    logic       ien_q,    ien_d;
    logic       flag_q,   flag_d;

    logic       wr_en;
    logic       wr_count;
    logic       wr_ctrl;
    logic       wr_status;
    logic       wr_reload;
    logic [9:0] div_max;
    logic       tick;
    logic       underflow;

    always_comb begin
        wr_en     = CS && !R_W;
        wr_count  = wr_en && (A == ADDR_COUNT);
        wr_ctrl   = wr_en && (A == ADDR_CTRL);
        wr_status = wr_en && (A == ADDR_STATUS);
        wr_reload = wr_en && (A == ADDR_RELOAD);

        case (div_q)
            2'b00:   div_max = 10'd0;
            2'b01:   div_max = 10'd7;
            2'b10:   div_max = 10'd63;
            default: div_max = 10'd1023;
        endcase

        tick      = run_q && (presc_q == div_max);
        underflow = tick && (count_q == 8'h00);

        // Prescaler restarts on any event that redefines the tick phase.
        if (!run_q || tick || wr_count || (wr_ctrl && (DB_IN[1:0] != div_q))) begin
            presc_d = 10'd0;
        end else begin
            presc_d = presc_q + 10'd1;
        end

        count_d = count_q;
        if (wr_count) begin
            count_d = DB_IN;
        end else if (tick) begin
            if (count_q != 8'h00) begin
                count_d = count_q - 8'd1;
            end else begin
                count_d = auto_q ? reload_q : 8'hFF;
            end
        end

        // Underflow beats a same-cycle STATUS clear; a COUNT write beats both.
        flag_d = flag_q;
        if (wr_count) begin
            flag_d = 1'b0;
        end else if (underflow) begin
            flag_d = 1'b1;
        end else if (wr_status && DB_IN[7]) begin
            flag_d = 1'b0;
        end

        div_d    = wr_ctrl ? DB_IN[1:0] : div_q;
        run_d    = wr_ctrl ? DB_IN[5]   : run_q;
        auto_d   = wr_ctrl ? DB_IN[6]   : auto_q;
        ien_d    = wr_ctrl ? DB_IN[7]   : ien_q;
        reload_d = wr_reload ? DB_IN : reload_q;
    end

    always_ff @(posedge CLK or negedge RES_N) begin
        if (!RES_N) begin
            count_q  <= 8'h00;
            reload_q <= RESET_RELOAD;
            presc_q  <= 10'd0;
            div_q    <= 2'b00;
            run_q    <= 1'b0;
            auto_q   <= 1'b0;
            ien_q    <= 1'b0;
            flag_q   <= 1'b0;
        end else begin
            count_q  <= count_d;
            reload_q <= reload_d;
            presc_q  <= presc_d;
            div_q    <= div_d;
            run_q    <= run_d;
            auto_q   <= auto_d;
            ien_q    <= ien_d;
            flag_q   <= flag_d;
        end
    end

    always_comb begin
        DB_OUT = 8'h00;
        if (CS && R_W) begin
            case (A)
                ADDR_COUNT:  DB_OUT = count_q;
                ADDR_CTRL:   DB_OUT = {ien_q, auto_q, run_q, 3'b000, div_q};
                ADDR_STATUS: DB_OUT = {flag_q, 7'b0000000};
                default:     DB_OUT = reload_q;
            endcase
        end
        IRQ_N = !(flag_q && ien_q);
    end

endmodule

// File: tb/tb_bus_timer.sv
// tb/tb_bus_timer.sv - scoreboard bench for bus_timer register map, counting and IRQ behaviour
module tb_bus_timer;

    logic       CLK;
    logic       RES_N;
    logic       CS;
    logic [1:0] A;
    logic       R_W;
    logic [7:0] DB_IN;
    logic [7:0] DB_OUT;
    logic       IRQ_N;

    typedef struct {
        string      tag;
        logic       is_irq;
        logic [7:0] exp;
    } sb_entry_t;

    sb_entry_t sb_q[$];
    int total = 0;
    int bad   = 0;

    bus_timer #(.RESET_RELOAD(8'hFF)) dut (
        .CLK    (CLK),
        .RES_N  (RES_N),
        .CS     (CS),
        .A      (A),
        .R_W    (R_W),
        .DB_IN  (DB_IN),
        .DB_OUT (DB_OUT),
        .IRQ_N  (IRQ_N)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic push_exp(input string tag, input logic is_irq, input logic [7:0] exp);
        sb_entry_t e;
        e.tag    = tag;
        e.is_irq = is_irq;
        e.exp    = exp;
        sb_q.push_back(e);
    endtask

    // Compare every pending expectation mid-cycle, then move just past the next rising edge.
    task automatic sample_cycle();
        sb_entry_t e;
        @(negedge CLK);
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            if (e.is_irq) check_eq(e.tag, {7'b0, IRQ_N}, e.exp);
            else          check_eq(e.tag, DB_OUT, e.exp);
        end
        @(posedge CLK);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic wr(input logic [1:0] a, input logic [7:0] d);
        CS = 1'b1; R_W = 1'b0; A = a; DB_IN = d;
        @(posedge CLK);
        #1;
        CS = 1'b0; R_W = 1'b1;
    endtask

    task automatic wr_nocs(input logic [1:0] a, input logic [7:0] d, input string tag);
        CS = 1'b0; R_W = 1'b0; A = a; DB_IN = d;
        push_exp(tag, 1'b0, 8'h00);
        sample_cycle();
        R_W = 1'b1;
    endtask

    task automatic rd(input logic [1:0] a, input logic [7:0] exp, input string tag);
        CS = 1'b1; R_W = 1'b1; A = a;
        push_exp(tag, 1'b0, exp);
        sample_cycle();
        CS = 1'b0;
    endtask

    task automatic push_irq(input logic exp, input string tag);
        push_exp(tag, 1'b1, {7'b0, exp});
    endtask

    initial begin
        RES_N = 1'b0; CS = 1'b0; R_W = 1'b1; A = 2'd0; DB_IN = 8'h00;
        repeat (2) @(posedge CLK);
        #1;
        RES_N = 1'b1;
        idle(1);

        // Reset mid-count with FLAG and IEN set
        wr(2'd3, 8'h33);
        wr(2'd0, 8'h01);
        wr(2'd1, 8'hA0);
        idle(4);
        push_irq(1'b0, "pre_rst_irq");
        rd(2'd2, 8'h80, "pre_rst_flag");
        RES_N = 1'b0;
        #2;
        RES_N = 1'b1;
        push_irq(1'b1, "rst_irq");
        rd(2'd0, 8'h00, "rst_count");
        rd(2'd1, 8'h00, "rst_ctrl");
        rd(2'd2, 8'h00, "rst_status");
        rd(2'd3, 8'hFF, "rst_reload");
        idle(5);
        rd(2'd0, 8'h00, "rst_no_resume");

        // /1 one-shot
        wr(2'd0, 8'h03);
        wr(2'd1, 8'hA0);
        rd(2'd0, 8'h03, "d1_c03");
        rd(2'd0, 8'h02, "d1_c02");
        rd(2'd0, 8'h01, "d1_c01");
        push_irq(1'b1, "d1_irq_pre");
        rd(2'd0, 8'h00, "d1_c00");
        push_irq(1'b0, "d1_irq");
        rd(2'd0, 8'hFF, "d1_wrap");
        rd(2'd2, 8'h80, "d1_flag");
        wr(2'd1, 8'h00);

        // /8 auto-reload
        wr(2'd3, 8'h05);
        wr(2'd0, 8'h01);
        wr(2'd1, 8'hE1);
        idle(15);
        rd(2'd2, 8'h00, "d8_flag_c15");
        push_irq(1'b0, "d8_irq");
        rd(2'd2, 8'h80, "d8_flag_c16");
        rd(2'd0, 8'h05, "d8_reload");
        wr(2'd2, 8'h80);
        idle(44);
        rd(2'd2, 8'h00, "d8_flag_c63");
        rd(2'd2, 8'h80, "d8_flag_c64");
        wr(2'd1, 8'h00);

        // STATUS clear colliding with underflow, COUNT write colliding with tick
        wr(2'd0, 8'h00);
        wr(2'd1, 8'hA0);
        wr(2'd2, 8'h80);
        rd(2'd2, 8'h80, "sts_collide");
        wr(2'd0, 8'h42);
        rd(2'd0, 8'h42, "cnt_collide");
        rd(2'd2, 8'h00, "cnt_collide_flag");
        wr(2'd1, 8'h00);

        // IEN masking
        wr(2'd0, 8'h00);
        wr(2'd1, 8'h20);
        wr(2'd1, 8'h00);
        push_irq(1'b1, "mask_irq");
        rd(2'd2, 8'h80, "mask_flag");
        wr(2'd1, 8'h80);
        push_irq(1'b0, "unmask_irq");
        rd(2'd0, 8'hFF, "mask_count");
        wr(2'd2, 8'h80);
        push_irq(1'b1, "clr_irq");
        rd(2'd2, 8'h00, "clr_flag");

        // CS=0 writes ignored, RUN=0 freezes COUNT
        wr(2'd0, 8'h10);
        for (int i = 0; i < 4; i++) wr_nocs(i[1:0], 8'h5A, "nocs_dbout");
        rd(2'd0, 8'h10, "nocs_count");
        rd(2'd1, 8'h80, "nocs_ctrl");
        rd(2'd2, 8'h00, "nocs_status");
        rd(2'd3, 8'h05, "nocs_reload");
        idle(2000);
        rd(2'd0, 8'h10, "frozen_count");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
